// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock sequencer with staggered per-domain release; define PLL_SEQ_LOSS_COUNT_EN to enable loss_cnt
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_DOMAINS         = 3,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_restart,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fault,
  output logic [3:0]             retry_cnt,
  output logic [7:0]             loss_cnt
);
  localparam int REL_LEN = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int MAX_A   = RST_HOLD_CYCLES > LOCK_STABLE_CYCLES ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = LOCK_TIMEOUT_CYCLES > MAX_A ? LOCK_TIMEOUT_CYCLES : MAX_A;
  localparam int MAX_C   = NUM_DOMAINS * STAGGER_CYCLES > MAX_B ? NUM_DOMAINS * STAGGER_CYCLES : MAX_B;
  localparam int CW      = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          sync1;
  logic          lock_s;
  assign cnt_inc = cnt + 1'b1;
  // Bit i stays in reset until e cycles have elapsed since RELEASE entry, e >= i*STAGGER
  function automatic logic [NUM_DOMAINS-1:0] rel_mask(input logic [CW-1:0] e);
    logic [NUM_DOMAINS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) m[i] = CW'(i * STAGGER_CYCLES) > e;
    return m;
  endfunction
`ifndef PLL_SEQ_LOSS_COUNT_EN
  assign loss_cnt = 8'd0;
`endif
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state      <= PLL_RST;
      cnt        <= '0;
      sync1      <= 1'b0;
      lock_s     <= 1'b0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      ready      <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= 4'd0;
`ifdef PLL_SEQ_LOSS_COUNT_EN
      loss_cnt   <= 8'd0;
`endif
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
      if (soft_restart) begin
        state      <= PLL_RST;
        cnt        <= '0;
        pll_rst    <= 1'b1;
        domain_rst <= '1;
        ready      <= 1'b0;
        fault      <= 1'b0;
        retry_cnt  <= 4'd0;
      end else begin
        case (state)
          PLL_RST: begin
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            if (cnt == CW'(RST_HOLD_CYCLES - 1)) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else cnt <= cnt_inc;
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
              cnt     <= '0;
              pll_rst <= 1'b1;
              if (retry_cnt + 4'd1 == 4'(MAX_RETRIES)) begin
                state     <= FAULT;
                fault     <= 1'b1;
                retry_cnt <= 4'(MAX_RETRIES);
              end else begin
                state     <= PLL_RST;
                retry_cnt <= retry_cnt + 4'd1;
              end
            end else cnt <= cnt_inc;
          end
          STABLE: begin
            if (!lock_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
              cnt        <= '0;
              domain_rst <= rel_mask('0);
              if (NUM_DOMAINS == 1) begin
                state     <= RUN;
                ready     <= 1'b1;
                retry_cnt <= 4'd0;
              end else state <= RELEASE;
            end else cnt <= cnt_inc;
          end
          RELEASE: begin
            if (!lock_s) begin
              state      <= PLL_RST;
              cnt        <= '0;
              pll_rst    <= 1'b1;
              domain_rst <= '1;
              ready      <= 1'b0;
            end else begin
              domain_rst <= rel_mask(cnt_inc);
              if (cnt_inc == CW'(REL_LEN)) begin
                state     <= RUN;
                cnt       <= '0;
                ready     <= 1'b1;
                retry_cnt <= 4'd0;
              end else cnt <= cnt_inc;
            end
          end
          RUN: begin
            if (!lock_s) begin
              state      <= PLL_RST;
              cnt        <= '0;
              pll_rst    <= 1'b1;
              domain_rst <= '1;
              ready      <= 1'b0;
`ifdef PLL_SEQ_LOSS_COUNT_EN
              if (loss_cnt != 8'hff) loss_cnt <= loss_cnt + 8'd1;
`endif
            end
          end
          default: begin
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            fault      <= 1'b1;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scoreboard bench for pll_reset_sequencer with small timing parameters
module tb_pll_reset_sequencer;
  localparam int P = 0, D = 1, R = 2, F = 3, C = 4, L = 5;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  localparam logic [7:0] LE = 8'd1;
`else
  localparam logic [7:0] LE = 8'd0;
`endif
  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  typedef struct {
    int         t;
    int         sel;
    logic [7:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];
  int   e = -4;
  int   n_assert = 0;
  int   n_fail = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
    .NUM_DOMAINS(3), .STAGGER_CYCLES(2), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .soft_restart(soft_restart),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  function automatic logic [7:0] obs(input int sel);
    return sel == P ? {7'd0, pll_rst} : sel == D ? {5'd0, domain_rst} : sel == R ? {7'd0, ready} :
           sel == F ? {7'd0, fault} : sel == C ? {4'd0, retry_cnt} : loss_cnt;
  endfunction

  task automatic compare(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, got, want, e);
    end
  endtask

  task automatic expect_at(input int t, input int sel, input logic [7:0] v, input string tag);
    exp_t x;
    x.t = t; x.sel = sel; x.v = v; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    e++;
    while (sb.size() > 0 && sb[0].t <= e) begin
      exp_t x;
      x = sb.pop_front();
      compare(x.tag, obs(x.sel), x.v);
    end
  endtask

  task automatic go_to(input int t);
    while (e < t) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", e);
    $fatal(1, "timeout");
  end

  initial begin
    expect_at(-1, P, 1, "rst_pll_rst");
    expect_at(-1, D, 7, "rst_domain_rst");
    expect_at(-1, R, 0, "rst_ready");
    expect_at(-1, F, 0, "rst_fault");
    expect_at(-1, C, 0, "rst_retry");
    expect_at(-1, L, 0, "rst_loss");
    go_to(0);
    rst = 1'b0;
    expect_at(3, P, 1, "pu_pll_rst_held");
    expect_at(4, P, 0, "pu_pll_rst_fall");
    go_to(10);
    pll_locked = 1'b1;
    expect_at(20, D, 7, "pu_dom_before");
    expect_at(21, D, 6, "pu_dom0_fall");
    expect_at(22, D, 6, "pu_dom_hold");
    expect_at(23, D, 4, "pu_dom1_fall");
    expect_at(24, R, 0, "pu_ready_early");
    expect_at(25, D, 0, "pu_dom2_fall");
    expect_at(25, R, 1, "pu_ready");
    expect_at(25, C, 0, "pu_retry");
    expect_at(25, F, 0, "pu_fault");
    go_to(27);
    pll_locked = 1'b0;
    expect_at(29, D, 0, "loss_dom_still_run");
    expect_at(29, R, 1, "loss_ready_still");
    expect_at(30, D, 7, "loss_dom_reset");
    expect_at(30, R, 0, "loss_ready");
    expect_at(30, P, 1, "loss_pll_rst");
    expect_at(30, L, LE, "loss_cnt1");
    expect_at(33, P, 1, "loss_pll_rst_held");
    expect_at(34, P, 0, "loss_pll_rst_fall");
    go_to(34);
    pll_locked = 1'b1;
    go_to(40);
    pll_locked = 1'b0;
    go_to(41);
    pll_locked = 1'b1;
    expect_at(45, D, 7, "glitch_no_early_release");
    expect_at(51, D, 7, "glitch_dom_before");
    expect_at(51, R, 0, "glitch_ready_before");
    expect_at(52, D, 6, "glitch_dom0_fall");
    expect_at(54, D, 4, "relock_dom1_fall");
    expect_at(56, D, 0, "relock_dom2_fall");
    expect_at(56, R, 1, "relock_ready");
    expect_at(56, L, LE, "relock_loss_kept");
    go_to(56);
    pll_locked = 1'b0;
    expect_at(59, L, 2 * LE, "nolock_loss_cnt2");
    expect_at(59, P, 1, "nolock_pll_rst");
    expect_at(63, P, 0, "nolock_pll_rst_fall");
    expect_at(94, P, 0, "to1_before");
    expect_at(94, C, 0, "to1_retry_before");
    expect_at(95, P, 1, "to1_pll_rst");
    expect_at(95, C, 1, "to1_retry");
    expect_at(98, P, 1, "to1_hold");
    expect_at(99, P, 0, "to1_release");
    expect_at(130, F, 0, "to2_fault_before");
    expect_at(130, C, 1, "to2_retry_before");
    expect_at(131, F, 1, "to2_fault");
    expect_at(131, C, 2, "to2_retry");
    expect_at(131, P, 1, "to2_pll_rst");
    expect_at(131, D, 7, "to2_dom");
    expect_at(140, F, 1, "fault_sticky");
    expect_at(140, R, 0, "fault_ready");
    go_to(140);
    soft_restart = 1'b1;
    expect_at(141, F, 0, "sr_fault_clr");
    expect_at(141, C, 0, "sr_retry_clr");
    expect_at(141, P, 1, "sr_pll_rst");
    go_to(141);
    soft_restart = 1'b0;
    expect_at(177, C, 1, "sim_retry1");
    expect_at(212, C, 1, "sim_retry_before");
    expect_at(212, P, 0, "sim_pll_rst_before");
    expect_at(212, F, 0, "sim_fault_before");
    go_to(212);
    soft_restart = 1'b1;
    expect_at(213, F, 0, "sim_fault_stays0");
    expect_at(213, C, 0, "sim_retry_clr");
    expect_at(213, P, 1, "sim_pll_rst");
    expect_at(213, D, 7, "sim_dom");
    expect_at(213, L, 2 * LE, "sim_loss_kept");
    go_to(213);
    soft_restart = 1'b0;
    pll_locked = 1'b1;
    expect_at(225, D, 7, "rel_dom_before");
    expect_at(226, D, 6, "rel_dom0_fall");
    expect_at(226, C, 0, "rel_retry");
    go_to(226);
    #5;
    rst = 1'b1;
    #1;
    compare("arst_dom", {5'd0, domain_rst}, 8'd7);
    compare("arst_pll_rst", {7'd0, pll_rst}, 8'd1);
    compare("arst_ready", {7'd0, ready}, 8'd0);
    compare("arst_fault", {7'd0, fault}, 8'd0);
    compare("arst_loss", loss_cnt, 8'd0);
    expect_at(229, D, 7, "arst_dom_held");
    expect_at(229, P, 1, "arst_pll_held");
    go_to(230);
    rst = 1'b0;
    expect_at(233, P, 1, "rerun_pll_held");
    expect_at(234, P, 0, "rerun_pll_fall");
    go_to(236);
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
